gpr_scoreboard: RTL
===================

Name: gpr_scoreboard

Overview:
Pending-write tracker on the read side of the 32x32 general-purpose register file. Each issued instruction that will write a GPR is recorded here. Write-back retires the record. Decode reads its source operands through this block, and it asserts Stall while a source register still has an older write in flight. Its bypass rule matches the register file's same-cycle write-through, so a retire that lands in the same cycle clears the hazard immediately.

Parameters:
AW, 5, register address width (2^AW registers; register 0 is never tracked)
CW, 2, per-register in-flight counter width (max 2^CW-1 outstanding writes per register)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous reset, active-high; clears all state
Flush  input  1  synchronous clear of all pending records (pipeline flush)
A1  input  AW  source register 1 address from decode
Use1  input  1  decode actually reads A1
A2  input  AW  source register 2 address from decode
Use2  input  1  decode actually reads A2
Issue  input  1  decode issues an instruction this cycle
IssueWe  input  1  issued instruction writes a GPR
IssueA3  input  AW  destination register of the issued instruction
Ret  input  1  write-back commits a GPR write this cycle (same as register file We)
RetA3  input  AW  write-back destination (same as register file A3)
Stall  output  1  combinational; decode must hold
Busy  output  1  registered; at least one register has a pending write
Err  output  1  registered, sticky; counter overflow or underflow detected

Behaviour:
- State: cnt[r], CW bits, for r = 1..2^AW-1. cnt[0] is constantly 0. Registered Busy and Err.
- Reset (Rst=1, asynchronous): all cnt=0, Busy=0, Err=0. This holds at any time, including mid-operation.
- hit1 = Use1 & (A1!=0) & (cnt[A1]!=0) & ~(Ret & RetA3==A1 & cnt[A1]==1). hit2 is the same with A2/Use2.
- Stall = hit1 | hit2, combinational. Stall does not depend on Issue or IssueA3 in the same cycle. Stall is 0 during Rst.
- Accepted issue: iss = Issue & IssueWe & ~Stall & (IssueA3!=0). An Issue while Stall=1 is ignored.
- Accepted retire: ret = Ret & (RetA3!=0).
- Per-register update at the clock edge, in priority order:
  1. Flush=1: all cnt=0. Same-cycle iss and ret are ignored. Err is unchanged.
  2. iss and ret on the same register: cnt is unchanged.
  3. iss only: if cnt==2^CW-1, cnt holds and Err<=1 (overflow). Otherwise cnt+1.
  4. ret only: if cnt==0, cnt holds and Err<=1 (underflow). Otherwise cnt-1.
- iss and ret on different registers update independently in the same cycle.
- Busy <= OR over the next-state cnt values. Busy therefore reflects the counters one cycle after the update, with no extra lag.
- Err clears only on Rst.
- Register 0 never stalls, never counts, and never raises Err.

Test Plan:
- Reset: assert Rst mid-cycle with cnt[5]=2 -> immediately cnt all 0, Busy=0, Err=0, and Stall=0 for A1=5, Use1=1.
- Basic RAW: issue IssueA3=8 at cycle 0; at cycle 1 set A1=8, Use1=1 -> Stall=1. Ret with RetA3=8 at cycle 3 -> Stall=0 in cycle 3 (bypass). Cycle 4: Busy=0.
- Multiple in flight: issue to register 9 twice -> cnt=2. A single Ret for 9 with A2=9, Use2=1 -> Stall stays 1. The second Ret -> Stall=0 in that cycle.
- Simultaneous issue and retire on register 4 with cnt=1 -> cnt stays 1 and Busy stays 1. A stalled Issue (A1 pending, IssueA3=6) -> cnt[6] stays 0.
- Boundaries: with CW=2, four issues to register 3 -> cnt=3 and Err=1 after the fourth. Ret to register 7 with cnt=0 -> Err=1. Issue or Ret to register 0 -> no change, Err=0. Use1=0 with A1 pending -> Stall=0.
- Flush: cnt[10]=2 and cnt[11]=1, with Flush and Ret to 10 in the same cycle -> all cnt 0, Busy=0 next cycle, Err unchanged.

Source files
------------

// File: rtl/gpr_scoreboard.sv
// ---------------------------------------------------------------------------
// gpr_scoreboard
//
// Pending-write tracker for the 32x32 general-purpose register file. Every
// issued instruction that writes a GPR bumps a small per-register in-flight
// counter; write-back decrements it. Decode source operands are checked
// against the counters and Stall is raised while an older write is still
// outstanding. A retire landing in the same cycle as the read clears the
// hazard immediately, matching the register file's write-through.
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst      in   asynchronous active-high reset, clears all state
//   Flush    in   synchronous clear of every pending record
//   A1/Use1  in   decode source 1 address / source 1 is actually read
//   A2/Use2  in   decode source 2 address / source 2 is actually read
//   Issue    in   decode issues an instruction this cycle
//   IssueWe  in   issued instruction writes a GPR
//   IssueA3  in   destination of the issued instruction
//   Ret      in   write-back commits a GPR write this cycle
//   RetA3    in   write-back destination
//   Stall    out  combinational; decode must hold
//   Busy     out  registered; some register has a pending write
//   Err      out  registered, sticky; counter overflow or underflow seen
// ---------------------------------------------------------------------------
module gpr_scoreboard #(
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Flush,
    input  logic [AW-1:0] A1,
    input  logic          Use1,
    input  logic [AW-1:0] A2,
    input  logic          Use2,
    input  logic          Issue,
    input  logic          IssueWe,
    input  logic [AW-1:0] IssueA3,
    input  logic          Ret,
    input  logic [AW-1:0] RetA3,
    output logic          Stall,
    output logic          Busy,
    output logic          Err
);

    localparam int unsigned NR      = 1 << AW;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q [NR];
    logic [CW-1:0] cnt_d [NR];
    logic          busy_q, busy_d;
    logic          err_q,  err_d;

    logic          hit1, hit2;
    logic          iss, ret;
    logic          is_i, is_r;

    // A source hits when it is read, is not r0, and still has a write in
    // flight that is not the last one retiring right now.
    always_comb begin
        hit1 = Use1 && (A1 != '0) && (cnt_q[A1] != '0)
               && !(Ret && (RetA3 == A1) && (cnt_q[A1] == CNT_ONE));
        hit2 = Use2 && (A2 != '0) && (cnt_q[A2] != '0)
               && !(Ret && (RetA3 == A2) && (cnt_q[A2] == CNT_ONE));
        Stall = hit1 | hit2;
    end

    assign iss = Issue && IssueWe && !Stall && (IssueA3 != '0);
    assign ret = Ret && (RetA3 != '0);

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        busy_d = 1'b0;
        is_i   = 1'b0;
        is_r   = 1'b0;
        for (int unsigned r = 1; r < NR; r++) begin
            is_i = iss && (IssueA3 == AW'(r));
            is_r = ret && (RetA3 == AW'(r));
            if (Flush) begin
                cnt_d[r] = '0;
            end else if (is_i && is_r) begin
                cnt_d[r] = cnt_q[r];
            end else if (is_i) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (is_r) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
            busy_d = busy_d | (cnt_d[r] != '0);
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign Busy = busy_q;
    assign Err  = err_q;

endmodule
